// File: rtl/rx_point_buffer_pkg.sv
// rx_point_pkg: shared constants and FSM state type for rx_point_buffer.
// Sync/end marker bytes and the receive-side state encoding.
`timescale 1ns/1ps
package rx_point_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h00;
  localparam logic [7:0] END_BYTE  = 8'h01;

  typedef enum logic [1:0] {
    SYNC,
    READ,
    COMMIT
  } state_t;

endpackage

// File: rtl/rx_point_buffer_if.sv
// rx_point_buffer_if: byte-in / draw-bank-out bundle of rx_point_buffer.
// master = receiver+drawer side, slave = buffer.
`timescale 1ns/1ps
interface rx_point_buffer_if #(
  parameter int AW   = 11,
  parameter int PT_W = 32
);
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            done_drawing;
  logic [AW-1:0]   index;
  logic [PT_W-1:0] point;
  logic [AW:0]     num_pts;
  logic            frame_valid;
  logic            swap;
  logic            overflow;
  logic            busy;

  modport master (
    output rx_valid, rx_data, done_drawing, index,
    input  point, num_pts, frame_valid, swap, overflow, busy
  );

  modport slave (
    input  rx_valid, rx_data, done_drawing, index,
    output point, num_pts, frame_valid, swap, overflow, busy
  );
endinterface

// File: rtl/rx_point_buffer_point_ram.sv
// point_ram: one bank of point storage, 1 write port + registered read.
// Ports: clk, rst_n, we/waddr/wdata write, raddr -> rdata (1-cycle).
`timescale 1ns/1ps
module point_ram #(
  parameter int DEPTH = 2048,
  parameter int PT_W  = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [PT_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [PT_W-1:0] rdata
);
  logic [PT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end
endmodule

// File: rtl/rx_point_buffer.sv
// rx_point_buffer: sync hunt, big-endian point assembly, ping-pong banks.
// Ports: clk, reset_n (async, active low), bus (rx_point_buffer_if.slave).
`timescale 1ns/1ps
module rx_point_buffer #(
  parameter int DEPTH       = 2048,
  parameter int X_W         = 12,
  parameter int Y_W         = 12,
  parameter int I_W         = 8,
  parameter int NBYTES      = 4,
  parameter int SYNC_LEN    = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  rx_point_buffer_if.slave bus
);
  import rx_point_pkg::*;

  localparam int AW   = $clog2(DEPTH);
  localparam int PT_W = X_W + Y_W + I_W;
  localparam int WW   = NBYTES * 8;
  localparam int OW   = $clog2(NBYTES + 1);
  localparam int ZW   = $clog2(SYNC_LEN + 1);
  localparam int GW   = $clog2(TIMEOUT_CYC);
  localparam logic [WW-1:0] END_W = {NBYTES{END_BYTE}};

  state_t        state_q, state_d;
  logic [WW-1:0] w_q, w_d, w_next;
  logic [OW-1:0] boff_q, boff_d;
  logic [ZW-1:0] zcnt_q, zcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW:0]   npts_q, npts_d;
  logic          bank_q, bank_d;
  logic          fv_q, fv_d;
  logic          swap_q, swap_d;
  logic          ovf_q, ovf_d;
  logic          commit_now;
  logic          wr_en;
  logic [PT_W-1:0] rd0, rd1;

  assign w_next = (w_q << 8) | WW'(bus.rx_data);

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    boff_d     = boff_q;
    zcnt_d     = zcnt_q;
    gap_d      = gap_q;
    fill_d     = fill_q;
    npts_d     = npts_q;
    bank_d     = bank_q;
    fv_d       = fv_q;
    swap_d     = 1'b0;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;
    commit_now = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (bus.rx_valid) begin
          if (bus.rx_data != SYNC_BYTE) begin
            zcnt_d = '0;
          end else if (zcnt_q == ZW'(SYNC_LEN - 1)) begin
            state_d = READ;
            fill_d  = '0;
            boff_d  = '0;
            zcnt_d  = '0;
            gap_d   = '0;
          end else begin
            zcnt_d = zcnt_q + 1'b1;
          end
        end
      end
      READ: begin
        if (bus.rx_valid) begin
          gap_d = '0;
          w_d   = w_next;
          if (boff_q == OW'(NBYTES - 1)) begin
            boff_d = '0;
            if (w_next == END_W) begin
              commit_now = 1'b1;
            end else if (fill_q == (AW+1)'(DEPTH)) begin
              ovf_d      = 1'b1;
              commit_now = 1'b1;
            end else begin
              wr_en  = 1'b1;
              fill_d = fill_q + 1'b1;
            end
          end else begin
            boff_d = boff_q + 1'b1;
          end
        end else if (gap_q == GW'(TIMEOUT_CYC - 1)) begin
          state_d = SYNC;
          zcnt_d  = '0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      COMMIT: commit_now = 1'b1;
      default: state_d = SYNC;
    endcase
    // With no frame on display the bank can be handed over at once;
    // otherwise hold the fill bank until the drawer ends a pass.
    if (commit_now) begin
      if (!fv_q || (state_q == COMMIT && bus.done_drawing)) begin
        bank_d  = ~bank_q;
        npts_d  = fill_q;
        fv_d    = 1'b1;
        swap_d  = 1'b1;
        zcnt_d  = '0;
        state_d = SYNC;
      end else begin
        state_d = COMMIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SYNC;
      w_q     <= '0;
      boff_q  <= '0;
      zcnt_q  <= '0;
      gap_q   <= '0;
      fill_q  <= '0;
      npts_q  <= '0;
      bank_q  <= 1'b0;
      fv_q    <= 1'b0;
      swap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      boff_q  <= boff_d;
      zcnt_q  <= zcnt_d;
      gap_q   <= gap_d;
      fill_q  <= fill_d;
      npts_q  <= npts_d;
      bank_q  <= bank_d;
      fv_q    <= fv_d;
      swap_q  <= swap_d;
      ovf_q   <= ovf_d;
    end
  end

  point_ram #(.DEPTH(DEPTH), .PT_W(PT_W)) u_bank0 (
    .clk  (clk),
    .rst_n(reset_n),
    .we   (wr_en & bank_q),
    .waddr(fill_q[AW-1:0]),
    .wdata(w_next[PT_W-1:0]),
    .raddr(bus.index),
    .rdata(rd0)
  );

  point_ram #(.DEPTH(DEPTH), .PT_W(PT_W)) u_bank1 (
    .clk  (clk),
    .rst_n(reset_n),
    .we   (wr_en & ~bank_q),
    .waddr(fill_q[AW-1:0]),
    .wdata(w_next[PT_W-1:0]),
    .raddr(bus.index),
    .rdata(rd1)
  );

  assign bus.point       = bank_q ? rd1 : rd0;
  assign bus.num_pts     = npts_q;
  assign bus.frame_valid = fv_q;
  assign bus.swap        = swap_q;
  assign bus.overflow    = ovf_q;
  assign bus.busy        = (state_q != SYNC);
endmodule
